// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, per-key press/release debounce,
// and a registered single-cycle event carrying the key code.
`timescale 1ns/1ps

module keypad_sync_bit (
    input  logic clk_27mhz,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;

    // Reset to the pulled-up (released) level so the first scan sample never
    // mistakes the reset value for a pressed row.
    always_ff @(posedge clk_27mhz or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

module keypad_scanner #(
    parameter int SCAN_DIV     = 27000,
    parameter int DEBOUNCE_CYC = 270000
) (
    input  logic       clk_27mhz,
    input  logic       reset_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_pulse,
    output logic [3:0] key_code,
    output logic       key_is_digit,
    output logic [3:0] digit_value,
    output logic       key_held
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEB_P,
        ST_PRESSED,
        ST_DEB_R
    } state_t;

    state_t           state;
    logic [3:0]       row_s;
    logic [1:0]       col_idx;
    logic [1:0]       col_nxt;
    logic [1:0]       lat_row;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic             hit;
    logic [1:0]       hit_row;
    logic             lat_hi;
    logic [3:0]       lat_code;

    for (genvar r = 0; r < 4; r++) begin : g_sync
        keypad_sync_bit u_sync (
            .clk_27mhz (clk_27mhz),
            .reset_n   (reset_n),
            .d         (row_n[r]),
            .q         (row_s[r])
        );
    end

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Walk rows from high to low so the lowest low row is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s[r]) begin
                hit     = 1'b1;
                hit_row = 2'(r);
            end
        end
    end

    assign col_nxt  = col_idx + 2'd1;
    assign lat_hi   = row_s[lat_row];
    assign lat_code = key_map(lat_row, col_idx);

    always_ff @(posedge clk_27mhz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_SCAN;
            col_idx      <= 2'd0;
            col_n        <= 4'b1110;
            lat_row      <= 2'd0;
            div_cnt      <= '0;
            deb_cnt      <= '0;
            key_pulse    <= 1'b0;
            key_is_digit <= 1'b0;
            key_held     <= 1'b0;
            key_code     <= 4'h0;
            digit_value  <= 4'h0;
        end else begin
            key_pulse    <= 1'b0;
            key_is_digit <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (hit) begin
                            lat_row <= hit_row;
                            deb_cnt <= '0;
                            state   <= ST_DEB_P;
                        end else begin
                            col_idx <= col_nxt;
                            col_n   <= ~(4'b0001 << col_nxt);
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_DEB_P: begin
                    if (lat_hi) begin
                        state   <= ST_SCAN;
                        div_cnt <= '0;
                        col_idx <= col_nxt;
                        col_n   <= ~(4'b0001 << col_nxt);
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= ST_PRESSED;
                        key_held  <= 1'b1;
                        key_pulse <= 1'b1;
                        key_code  <= lat_code;
                        if (lat_code <= 4'd9) begin
                            key_is_digit <= 1'b1;
                            digit_value  <= lat_code;
                        end
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (lat_hi) begin
                        deb_cnt <= '0;
                        state   <= ST_DEB_R;
                    end
                end
                ST_DEB_R: begin
                    // Re-closing during release debounce resumes the hold with no new event.
                    if (!lat_hi) begin
                        state <= ST_PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        state    <= ST_SCAN;
                        key_held <= 1'b0;
                        div_cnt  <= '0;
                        col_idx  <= col_nxt;
                        col_n    <= ~(4'b0001 << col_nxt);
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix model driving row_n from col_n.
`timescale 1ns/1ps

module tb_keypad_scanner;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CYC = 8;

    logic       clk_27mhz = 1'b0;
    logic       reset_n   = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_pulse;
    logic [3:0] key_code;
    logic       key_is_digit;
    logic [3:0] digit_value;
    logic       key_held;

    logic [3:0][3:0] keys;
    int errors = 0;
    int checks = 0;
    int pulse_total = 0;
    int digit_total = 0;
    int stray_digit = 0;
    logic [3:0] last_code = 4'h0;
    logic       last_digit = 1'b0;

    always #5 clk_27mhz = ~clk_27mhz;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut (
        .clk_27mhz    (clk_27mhz),
        .reset_n      (reset_n),
        .row_n        (row_n),
        .col_n        (col_n),
        .key_pulse    (key_pulse),
        .key_code     (key_code),
        .key_is_digit (key_is_digit),
        .digit_value  (digit_value),
        .key_held     (key_held)
    );

    // A pressed key shorts its row to its column; a row reads low only while that column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            if (|(keys[r] & ~col_n)) row_n[r] = 1'b0;
    end

    always @(negedge clk_27mhz) begin
        if (key_pulse) begin
            pulse_total = pulse_total + 1;
            last_code   = key_code;
            last_digit  = key_is_digit;
            if (key_is_digit) digit_total = digit_total + 1;
        end
        if (key_is_digit && !key_pulse) stray_digit = stray_digit + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_27mhz);
    endtask

    task automatic test_reset();
        int p0;
        logic [3:0] exp;
        keys = '0;
        reset_n = 1'b0;
        tick(3);
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL reset_col_n: got %b want 1110", col_n); end
        checks++; if ({key_pulse, key_is_digit, key_held} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {key_pulse, key_is_digit, key_held}); end
        checks++; if ({key_code, digit_value} !== 8'h00) begin errors++; $display("FAIL reset_codes: got %h want 00", {key_code, digit_value}); end
        reset_n = 1'b1;
        p0 = pulse_total;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            exp = ~(4'b0001 << ((k / 4) % 4));
            checks++; if (col_n !== exp) begin errors++; $display("FAIL scan_col_n[%0d]: got %b want %b", k, col_n, exp); end
        end
        tick(184);
        checks++; if (pulse_total !== p0) begin errors++; $display("FAIL idle_no_pulse: got %0d pulses want 0", pulse_total - p0); end
    endtask

    task automatic test_digit_press();
        int p0, d0;
        p0 = pulse_total; d0 = digit_total;
        keys[1][1] = 1'b1;
        tick(40);
        checks++; if (pulse_total - p0 !== 1) begin errors++; $display("FAIL digit_pulse_count: got %0d want 1", pulse_total - p0); end
        checks++; if (digit_total - d0 !== 1) begin errors++; $display("FAIL digit_strobe_count: got %0d want 1", digit_total - d0); end
        checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL digit_key_code: got %h want 5", key_code); end
        checks++; if (digit_value !== 4'h5) begin errors++; $display("FAIL digit_value: got %h want 5", digit_value); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL digit_held: got %b want 1", key_held); end
        keys[1][1] = 1'b0;
        tick(8);
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL digit_held_after_release: got %b want 1", key_held); end
        tick(12);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL digit_released: got %b want 0", key_held); end
        checks++; if (pulse_total - p0 !== 1) begin errors++; $display("FAIL digit_no_release_event: got %0d want 1", pulse_total - p0); end
    endtask

    task automatic test_non_digit();
        int p0, d0;
        p0 = pulse_total; d0 = digit_total;
        keys[2][0] = 1'b1; tick(40);
        keys[2][0] = 1'b0; tick(20);
        checks++; if (digit_value !== 4'h7) begin errors++; $display("FAIL prior_digit_7: got %h want 7", digit_value); end
        keys[3][3] = 1'b1; tick(40);
        checks++; if (pulse_total - p0 !== 2) begin errors++; $display("FAIL nondigit_pulse_count: got %0d want 2", pulse_total - p0); end
        checks++; if (digit_total - d0 !== 1) begin errors++; $display("FAIL nondigit_strobe_count: got %0d want 1", digit_total - d0); end
        checks++; if (key_code !== 4'hD) begin errors++; $display("FAIL nondigit_key_code: got %h want d", key_code); end
        checks++; if (digit_value !== 4'h7) begin errors++; $display("FAIL nondigit_digit_value: got %h want 7", digit_value); end
        checks++; if (last_digit !== 1'b0) begin errors++; $display("FAIL nondigit_is_digit: got %b want 0", last_digit); end
        keys[3][3] = 1'b0; tick(20);
    endtask

    task automatic test_bounce();
        int p0;
        p0 = pulse_total;
        keys[0][0] = 1'b1; tick(5);
        keys[0][0] = 1'b0; tick(2);
        keys[0][0] = 1'b1; tick(30);
        keys[0][0] = 1'b0; tick(20);
        checks++; if (pulse_total - p0 !== 1) begin errors++; $display("FAIL bounce_pulse_count: got %0d want 1", pulse_total - p0); end
        checks++; if (last_code !== 4'h1) begin errors++; $display("FAIL bounce_code: got %h want 1", last_code); end
        p0 = pulse_total;
        keys[0][0] = 1'b1; tick(5);
        keys[0][0] = 1'b0; tick(30);
        checks++; if (pulse_total - p0 !== 0) begin errors++; $display("FAIL glitch_pulse_count: got %0d want 0", pulse_total - p0); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL glitch_held: got %b want 0", key_held); end
    endtask

    task automatic test_release_rollover();
        int p0, p1;
        p0 = pulse_total;
        keys[3][1] = 1'b1;
        for (int i = 0; i < 60 && key_held !== 1'b1; i++) tick(1);
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL roll_hold_timeout: got %b want 1", key_held); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL roll_code0: got %h want 0", key_code); end
        keys[2][2] = 1'b1; tick(30);
        checks++; if (pulse_total - p0 !== 1) begin errors++; $display("FAIL roll_ignored: got %0d want 1", pulse_total - p0); end
        keys[3][1] = 1'b0; tick(3);
        keys[3][1] = 1'b1; tick(3);
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL chatter_held: got %b want 1", key_held); end
        keys[3][1] = 1'b0; tick(6);
        checks++; if (pulse_total - p0 !== 1 || key_code !== 4'h0) begin errors++; $display("FAIL chatter_no_event: got %0d/%h want 1/0", pulse_total - p0, key_code); end
        p1 = pulse_total;
        for (int i = 0; i < 60 && pulse_total == p1; i++) tick(1);
        checks++; if (pulse_total - p0 !== 2) begin errors++; $display("FAIL roll_second_event: got %0d want 2", pulse_total - p0); end
        checks++; if (last_code !== 4'h9) begin errors++; $display("FAIL roll_code9: got %h want 9", last_code); end
        keys[2][2] = 1'b0; tick(20);
    endtask

    task automatic test_reset_mid_hold();
        int p0;
        keys[0][2] = 1'b1;
        for (int i = 0; i < 60 && key_held !== 1'b1; i++) tick(1);
        checks++; if (key_held !== 1'b1 || key_code !== 4'h3) begin errors++; $display("FAIL mid_pre_hold: got %b/%h want 1/3", key_held, key_code); end
        @(posedge clk_27mhz); #2;
        reset_n = 1'b0;
        #1;
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL mid_reset_held: got %b want 0", key_held); end
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL mid_reset_col_n: got %b want 1110", col_n); end
        checks++; if ({key_code, digit_value} !== 8'h00) begin errors++; $display("FAIL mid_reset_codes: got %h want 00", {key_code, digit_value}); end
        tick(2);
        reset_n = 1'b1;
        p0 = pulse_total;
        for (int i = 0; i < 60 && pulse_total == p0; i++) tick(1);
        tick(20);
        checks++; if (pulse_total - p0 !== 1) begin errors++; $display("FAIL mid_fresh_count: got %0d want 1", pulse_total - p0); end
        checks++; if (last_code !== 4'h3 || key_held !== 1'b1) begin errors++; $display("FAIL mid_fresh_event: got %h/%b want 3/1", last_code, key_held); end
        keys[0][2] = 1'b0; tick(20);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL mid_final_release: got %b want 0", key_held); end
    endtask

    initial begin
        keys = '0;
        test_reset();
        test_digit_press();
        test_non_digit();
        test_bounce();
        test_release_rollover();
        test_reset_mid_hold();
        checks++; if (stray_digit !== 0) begin errors++; $display("FAIL stray_digit_strobe: got %0d want 0", stray_digit); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans a 4x4 matrix keypad and debounces each key press and release.
- Emits exactly one single-cycle event per physical press, carrying a 4-bit key code.
- Sits directly upstream of the calculator FSM controller: `key_is_digit` and `digit_value` connect straight to its keypad inputs.
- All logic runs on `clk_27mhz`.

## Interface
Parameters:
- `SCAN_DIV`, default 27000: clock cycles each column is driven (1 ms at 27 MHz); must be ≥ 2.
- `DEBOUNCE_CYC`, default 270000: consecutive stable cycles required to accept a press or a release (10 ms); must be ≥ 2.

Ports:
- `clk_27mhz`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `row_n`  in  4  keypad rows, active-low, externally pulled up, asynchronous to the clock.
- `col_n`  out  4  column drive, one-hot active-low.
- `key_pulse`  out  1  one-cycle strobe for any accepted key.
- `key_code`  out  4  code of the last accepted key.
- `key_is_digit`  out  1  one-cycle strobe, asserted only when the accepted key is 0–9.
- `digit_value`  out  4  binary value of the last accepted digit key.
- `key_held`  out  1  high while an accepted key is still held down.

## Operation
- **Row synchroniser.** `row_n` passes through a 2-flop synchroniser. All logic uses the synchronised value `row_s`.
- **Key map** (row r, column c → code):
  - r0: 1, 2, 3, A(0xA)
  - r1: 4, 5, 6, B(0xB)
  - r2: 7, 8, 9, C(0xC)
  - r3: \*(0xE), 0, #(0xF), D(0xD)
- **Multiple rows low in one column.** The lowest row index wins.
- **State machine:**
  - **SCAN**
    - Drives column `col_idx` low and runs the period counter from 0 to `SCAN_DIV-1`.
    - On the last cycle of the period, samples `row_s`:
      - any row low → latch `col_idx` and the winning row, clear the debounce counter, go to DEBOUNCE_P;
      - otherwise → `col_idx` advances (3 wraps to 0) and the period counter restarts.
  - **DEBOUNCE_P**
    - Column held; rotation frozen.
    - Each cycle the latched row is low, the counter increments.
    - Latched row high on any cycle → return to SCAN, advancing to the next column, no event.
    - Counter at `DEBOUNCE_CYC-1` with the row still low → go to PRESSED and fire the event.
  - **PRESSED**
    - Column held; `key_held`=1.
    - Latched row reads high → clear the counter, go to DEBOUNCE_R.
  - **DEBOUNCE_R**
    - Counter increments while the latched row is high.
    - Row low again → back to PRESSED (no new event).
    - Counter at `DEBOUNCE_CYC-1` with the row high → go to SCAN at the next column, with `key_held`=0.
- **Event** (registered, fires on the DEBOUNCE_P→PRESSED transition):
  - `key_pulse`=1 for exactly one cycle.
  - `key_code` updates in the same cycle and holds until the next event.
  - Code 0–9 → `key_is_digit`=1 for that same cycle, and `digit_value`=code (holds until the next digit event).
  - Codes A–F → `digit_value` is unchanged and `key_is_digit` stays 0.
- **Rollover.** Presses in other columns while in PRESSED or DEBOUNCE_R are ignored, because only the latched column is driven. No rollover events are generated.

## Timing
- **Reset values.** Asynchronous reset, effective immediately, including mid-debounce or mid-hold:
  - state SCAN, `col_idx`=0, `col_n`=4'b1110;
  - `key_pulse`=0, `key_is_digit`=0, `key_held`=0;
  - `key_code`=0, `digit_value`=0;
  - all counters and the synchroniser cleared.
  - No event fires after reset deasserts unless a full press is debounced again.
- **`col_n`.** Registered; changes only on a period boundary in SCAN.
- **Press latency.** From `row_n` falling to the event:
  - 2 cycles of synchroniser;
  - up to `SCAN_DIV` cycles waiting for the sample point;
  - `DEBOUNCE_CYC` cycles of debounce;
  - +1 cycle for the registered event.
  - Minimum with the column already driven and sampled immediately: 2 + `DEBOUNCE_CYC` + 1.
- **Release.** `key_held` falls in the cycle after `DEBOUNCE_CYC` consecutive high samples.
- **Bounce.** A glitch shorter than `DEBOUNCE_CYC` cycles never produces an event. Any high sample during DEBOUNCE_P aborts it.
- **Counter width.** Counters are `$clog2(max)` bits and never wrap; they saturate by state exit.

## Test plan
Parameters for the bench: `SCAN_DIV`=4, `DEBOUNCE_CYC`=8.

1. **Reset.** Hold `reset_n`=0, then release with `row_n`=4'hF → `col_n` cycles 1110, 1101, 1011, 0111, 1110…, changing every 4 cycles; no `key_pulse` over 200 cycles.
2. **Digit press.** Hold row 1 low whenever column 1 is driven (key 5) for 40 cycles → exactly one `key_pulse` and `key_is_digit`; `key_code`=5, `digit_value`=5; `key_held`=1 until 8 cycles after release.
3. **Non-digit key.** Press row 3 / column 3 (D) after a prior digit 7 → `key_pulse`=1, `key_is_digit`=0, `key_code`=0xD, `digit_value` stays 7.
4. **Bounce.** Row 0 / column 0 low for 5 cycles, high 2, low 30 → exactly one event, code 1; a 5-cycle-only glitch produces none.
5. **Release bounce and rollover.** Hold key 0 (row 3, column 1), release with 3-cycle chatter, and press key 9 in another column while 0 is held → single event for 0; no event for 9 until 0 has released and 9 is re-sampled.
6. **Reset mid-hold.** Pulse `reset_n` low while in PRESSED → `key_held` drops immediately, `col_n`=1110, `key_code`=0; holding the key afterwards yields one fresh event after debounce.
